// File: rtl/cc_speedtimer_multi_if.sv
// Control and tick bundle for the multi-channel lane speed timer.
// Limits are packed: channel k occupies limit[k*DATAWIDTH +: DATAWIDTH].
`timescale 1ns/1ps
interface cc_speedtimer_multi_if #(
  parameter int CHANNELS  = 4,
  parameter int DATAWIDTH = 16
);
  logic [CHANNELS*DATAWIDTH-1:0] limit;
  logic                          load;
  logic [CHANNELS-1:0]           enable;
  logic                          pause;
  logic                          sync;
  logic [CHANNELS-1:0]           t0_n;

  modport master (
    output limit, load, enable, pause, sync,
    input  t0_n
  );

  modport slave (
    input  limit, load, enable, pause, sync,
    output t0_n
  );
endinterface

// File: rtl/cc_speedtimer_multi.sv
// Multi-channel speed timer for lane objects. Each channel counts run
// cycles up to its own active limit and emits a one-cycle active-low tick
// on wrap, so the tick period is active+1 run cycles. New limits land in a
// shadow register and only become active at wrap, enable-off, stall (limit
// 0) or sync, which keeps cnt <= active and avoids mid-period glitches.
// Optional feature macro: CC_SPEEDTIMER_PRESCALER_EN divides the run
// strobe by PRESCALE; without it every unpaused cycle is a run cycle.
`timescale 1ns/1ps
module cc_speedtimer_multi #(
  parameter int CHANNELS  = 4,
  parameter int DATAWIDTH = 16,
  parameter int PRESCALE  = 4
) (
  input  logic                  CC_SPEEDTIMER_CLOCK_50,
  input  logic                  CC_SPEEDTIMER_RESET_InHigh,
  cc_speedtimer_multi_if.slave  bus
);

  typedef logic [DATAWIDTH-1:0] word_t;

  // What a channel does on the next edge, in priority order
  typedef enum logic [1:0] {
    ACT_RESTART,  // sync, disabled or stalled: clear count, take new limit
    ACT_HOLD,     // no run strobe: freeze count and limit
    ACT_WRAP,     // count reached limit: clear, take new limit, tick
    ACT_COUNT     // advance count
  } act_e;

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("cc_speedtimer_multi: CHANNELS must be 1..16");
  end
  if (PRESCALE < 2 || PRESCALE > 255) begin : g_bad_prescale
    $error("cc_speedtimer_multi: PRESCALE must be 2..255");
  end

  logic clk;
  logic rst;
  assign clk = CC_SPEEDTIMER_CLOCK_50;
  assign rst = CC_SPEEDTIMER_RESET_InHigh;

  word_t               cnt        [CHANNELS];
  word_t               shadow     [CHANNELS];
  word_t               active     [CHANNELS];
  word_t               newlim     [CHANNELS];
  word_t               cnt_nxt    [CHANNELS];
  word_t               active_nxt [CHANNELS];
  act_e                act        [CHANNELS];
  logic [CHANNELS-1:0] t0_n;
  logic [CHANNELS-1:0] t0_nxt;
  logic                strobe;
  logic                run;

`ifdef CC_SPEEDTIMER_PRESCALER_EN
  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic [7:0] prescale_cnt;

  // Run-strobe divider; frozen while paused so its phase survives a pause
  always_ff @(posedge clk) begin
    if (rst || bus.sync) begin
      prescale_cnt <= '0;
    end else if (!bus.pause) begin
      prescale_cnt <= (prescale_cnt == PRE_LAST) ? 8'd0 : prescale_cnt + 8'd1;
    end
  end

  assign strobe = (prescale_cnt == PRE_LAST);
`else
  assign strobe = 1'b1;
`endif

  assign run = !bus.pause && strobe;

  // A load in the same cycle as a limit update bypasses the shadow register
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      newlim[k] = bus.load ? bus.limit[k*DATAWIDTH +: DATAWIDTH] : shadow[k];
    end
  end

  // Decode each channel's action from the priority chain
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      act[k] = ACT_COUNT;
      if (bus.sync || !bus.enable[k] || (active[k] == '0)) begin
        act[k] = ACT_RESTART;
      end else if (!run) begin
        act[k] = ACT_HOLD;
      end else if (cnt[k] == active[k]) begin
        act[k] = ACT_WRAP;
      end
    end
  end

  // Next count, next active limit and next tick level per channel
  always_comb begin
    t0_nxt = '1;
    for (int k = 0; k < CHANNELS; k++) begin
      cnt_nxt[k]    = cnt[k];
      active_nxt[k] = active[k];
      case (act[k])
        ACT_RESTART: begin
          cnt_nxt[k]    = '0;
          active_nxt[k] = newlim[k];
        end
        ACT_WRAP: begin
          cnt_nxt[k]    = '0;
          active_nxt[k] = newlim[k];
          t0_nxt[k]     = 1'b0;
        end
        ACT_COUNT: begin
          cnt_nxt[k] = cnt[k] + DATAWIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Channel state registers; ticks idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt[k]    <= '0;
        active[k] <= '0;
      end
      t0_n <= '1;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt[k]    <= cnt_nxt[k];
        active[k] <= active_nxt[k];
      end
      t0_n <= t0_nxt;
    end
  end

  // Shadow limits: every channel captures its bus slice on a load strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        shadow[k] <= '0;
      end
    end else if (bus.load) begin
      for (int k = 0; k < CHANNELS; k++) begin
        shadow[k] <= bus.limit[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign bus.t0_n = t0_n;

endmodule

// File: tb/tb_cc_speedtimer_multi.sv
// Self-checking bench for cc_speedtimer_multi: directed scenarios with
// period/latency expectations plus randomized traffic against a
// cycle-level reference model built from the channel rules.
`timescale 1ns/1ps
module tb_cc_speedtimer_multi;
  localparam int CH   = 4;
  localparam int DW   = 6;
  localparam int PS   = 4;
  localparam int BW   = CH * DW;
  localparam int LMAX = (1 << DW) - 1;
`ifdef CC_SPEEDTIMER_PRESCALER_EN
  localparam int SCALE = PS;
`else
  localparam int SCALE = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cc_speedtimer_multi_if #(.CHANNELS(CH), .DATAWIDTH(DW)) bus ();

  cc_speedtimer_multi #(.CHANNELS(CH), .DATAWIDTH(DW), .PRESCALE(PS)) dut (
    .CC_SPEEDTIMER_CLOCK_50     (clk),
    .CC_SPEEDTIMER_RESET_InHigh (rst),
    .bus                        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Reference model state (integers, one entry per channel)
  int            m_cnt [CH];
  int            m_act [CH];
  int            m_sh  [CH];
  logic [CH-1:0] m_t0;
  int            m_pre;
  int            tq [CH][$];

  function automatic bit model_strobe();
`ifdef CC_SPEEDTIMER_PRESCALER_EN
    return (m_pre == PS - 1);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_step(input logic r, input logic [BW-1:0] lb, input logic ld,
                                     input logic [CH-1:0] en, input logic ps, input logic sy);
    bit run;
    int lim_in;
    int nl;
    run = !ps && model_strobe();
    if (r || sy) m_pre = 0;
    else if (!ps) m_pre = (m_pre + 1) % PS;
    if (r) begin
      for (int k = 0; k < CH; k++) begin
        m_cnt[k] = 0; m_act[k] = 0; m_sh[k] = 0;
      end
      m_t0 = '1;
      return;
    end
    for (int k = 0; k < CH; k++) begin
      lim_in = int'(lb[k*DW +: DW]);
      nl     = ld ? lim_in : m_sh[k];
      if (ld) m_sh[k] = lim_in;
      m_t0[k] = 1'b1;
      if (sy || !en[k] || m_act[k] == 0) begin
        m_cnt[k] = 0; m_act[k] = nl;
      end else if (!run) begin
        // frozen
      end else if (m_cnt[k] == m_act[k]) begin
        m_cnt[k] = 0; m_act[k] = nl; m_t0[k] = 1'b0;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endfunction

  function automatic logic [BW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [BW-1:0] v;
    v = '0;
    v[0*DW +: DW] = DW'(a);
    v[1*DW +: DW] = DW'(b);
    v[2*DW +: DW] = DW'(c);
    v[3*DW +: DW] = DW'(d);
    return v;
  endfunction

  function automatic logic [BW-1:0] junk();
    return BW'($urandom);
  endfunction

  task automatic cycle(input logic r, input logic [BW-1:0] lb, input logic ld,
                       input logic [CH-1:0] en, input logic ps, input logic sy);
    rst = r; bus.limit = lb; bus.load = ld; bus.enable = en; bus.pause = ps; bus.sync = sy;
    @(posedge clk);
    #1;
    model_step(r, lb, ld, en, ps, sy);
    edge_n++;
    for (int k = 0; k < CH; k++) if (bus.t0_n[k] === 1'b0) tq[k].push_back(edge_n);
  endtask

  task automatic clear_ticks();
    for (int k = 0; k < CH; k++) tq[k].delete();
  endtask

  task automatic test_reset();
    cycle(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, junk(), 1'b1, '1, 1'b0, 1'b0);
    n_checks++;
    if (bus.t0_n !== {CH{1'b1}}) begin
      n_fail++; $display("FAIL reset_t0 got=%b exp=%b", bus.t0_n, {CH{1'b1}});
    end
    // Limits are 0 after reset, so enabled channels stay stalled
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, junk(), 1'b0, '1, 1'b0, 1'b0);
      n_checks++;
      if (bus.t0_n !== {CH{1'b1}}) begin
        n_fail++; $display("FAIL reset_stall edge=%0d got=%b exp=%b", edge_n, bus.t0_n, {CH{1'b1}});
      end
    end
  endtask

  task automatic test_basic_period();
    int base;
    cycle(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, pack4(3, 0, 0, 0), 1'b1, '0, 1'b0, 1'b0);
    base = edge_n;
    clear_ticks();
    for (int i = 0; i < 20 * SCALE; i++) begin
      cycle(1'b0, junk(), 1'b0, 4'b0001, 1'b0, 1'b0);
      n_checks++;
      if (bus.t0_n !== m_t0) begin
        n_fail++; $display("FAIL basic_t0 edge=%0d got=%b exp=%b", edge_n, bus.t0_n, m_t0);
      end
    end
`ifndef CC_SPEEDTIMER_PRESCALER_EN
    n_checks++;
    if (tq[0].size() == 0 || tq[0][0] - base != 4) begin
      n_fail++;
      $display("FAIL basic_first_tick got=%0d exp=4", (tq[0].size() == 0) ? -1 : tq[0][0] - base);
    end
`endif
    n_checks++;
    if (tq[0].size() < 3) begin
      n_fail++; $display("FAIL basic_tick_count got=%0d exp>=3", tq[0].size());
    end
    for (int i = 1; i < tq[0].size(); i++) begin
      n_checks++;
      if (tq[0][i] - tq[0][i-1] != 4 * SCALE) begin
        n_fail++; $display("FAIL basic_interval got=%0d exp=%0d", tq[0][i] - tq[0][i-1], 4 * SCALE);
      end
    end
  endtask

  task automatic test_independent();
    int lims [CH];
    lims = '{1, 2, 5, 0};
    cycle(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, pack4(lims[0], lims[1], lims[2], lims[3]), 1'b1, '0, 1'b0, 1'b0);
    clear_ticks();
    for (int i = 0; i < 36 * SCALE; i++) begin
      cycle(1'b0, junk(), 1'b0, '1, 1'b0, 1'b0);
      n_checks++;
      if (bus.t0_n !== m_t0) begin
        n_fail++; $display("FAIL indep_t0 edge=%0d got=%b exp=%b", edge_n, bus.t0_n, m_t0);
      end
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 1; i < tq[k].size(); i++) begin
        n_checks++;
        if (tq[k][i] - tq[k][i-1] != (lims[k] + 1) * SCALE) begin
          n_fail++;
          $display("FAIL indep_interval ch=%0d got=%0d exp=%0d", k, tq[k][i] - tq[k][i-1], (lims[k] + 1) * SCALE);
        end
      end
    end
    n_checks++;
    if (tq[3].size() != 0) begin
      n_fail++; $display("FAIL indep_ch3_ticks got=%0d exp=0", tq[3].size());
    end
  endtask

  task automatic test_reload();
    int ph, nt, load_edge;
    int tt [7];
    logic ld;
    logic [BW-1:0] lb;
    cycle(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, pack4(7, 0, 0, 0), 1'b1, '0, 1'b0, 1'b0);
    ph = 0; nt = 0; load_edge = -1;
    for (int i = 0; i < 300 * SCALE && nt < 6; i++) begin
      ld = 1'b0; lb = junk();
      if (ph == 1 && m_cnt[0] == 4) begin
        ld = 1'b1; lb = pack4(2, 0, 0, 0); ph = 2;
      end else if (ph == 3) begin
        ld = 1'b1; lb = pack4(7, 0, 0, 0); ph = 4;
      end else if (ph == 5 && m_cnt[0] == 7 && m_act[0] == 7 && model_strobe()) begin
        ld = 1'b1; lb = pack4(2, 0, 0, 0); ph = 6; load_edge = edge_n + 1;
      end
      cycle(1'b0, lb, ld, 4'b0001, 1'b0, 1'b0);
      n_checks++;
      if (bus.t0_n !== m_t0) begin
        n_fail++; $display("FAIL reload_t0 edge=%0d got=%b exp=%b", edge_n, bus.t0_n, m_t0);
      end
      if (bus.t0_n[0] === 1'b0) begin
        nt++; tt[nt] = edge_n;
        if (nt == 1) ph = 1;
        if (nt == 3) ph = 3;
        if (nt == 4) ph = 5;
      end
    end
    n_checks++;
    if (nt < 6) begin
      n_fail++; $display("FAIL reload_timeout got=%0d ticks exp=6", nt);
    end else begin
      n_checks += 5;
      if (tt[2] - tt[1] != 8 * SCALE) begin n_fail++; $display("FAIL reload_old_period got=%0d exp=%0d", tt[2] - tt[1], 8 * SCALE); end
      if (tt[3] - tt[2] != 3 * SCALE) begin n_fail++; $display("FAIL reload_new_period got=%0d exp=%0d", tt[3] - tt[2], 3 * SCALE); end
      if (tt[4] - tt[3] != 3 * SCALE) begin n_fail++; $display("FAIL reload_shrink_done got=%0d exp=%0d", tt[4] - tt[3], 3 * SCALE); end
      if (tt[5] != load_edge)         begin n_fail++; $display("FAIL reload_wrap_tick got=%0d exp=%0d", tt[5], load_edge); end
      if (tt[6] - tt[5] != 3 * SCALE) begin n_fail++; $display("FAIL reload_wrap_immediate got=%0d exp=%0d", tt[6] - tt[5], 3 * SCALE); end
    end
  endtask

  task automatic test_pause();
    int ph, nt, pleft, t1, t2;
    logic ps;
    cycle(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, pack4(9, 0, 0, 0), 1'b1, '0, 1'b0, 1'b0);
    ph = 0; nt = 0; pleft = 0; t1 = 0; t2 = 0;
    for (int i = 0; i < 100 * SCALE && nt < 2; i++) begin
      ps = 1'b0;
      if (ph == 1 && m_cnt[0] == 6) begin ph = 2; pleft = 5; end
      if (ph == 2 && pleft > 0) begin ps = 1'b1; pleft--; end
      cycle(1'b0, junk(), 1'b0, 4'b0001, ps, 1'b0);
      n_checks++;
      if (bus.t0_n !== m_t0) begin
        n_fail++; $display("FAIL pause_t0 edge=%0d got=%b exp=%b", edge_n, bus.t0_n, m_t0);
      end
      if (ps) begin
        n_checks++;
        if (bus.t0_n[0] !== 1'b1) begin n_fail++; $display("FAIL pause_no_tick edge=%0d got=%b exp=1", edge_n, bus.t0_n[0]); end
      end
      if (bus.t0_n[0] === 1'b0) begin
        nt++;
        if (nt == 1) begin t1 = edge_n; ph = 1; end
        if (nt == 2) t2 = edge_n;
      end
    end
    n_checks++;
    if (nt < 2 || t2 - t1 != 10 * SCALE + 5) begin
      n_fail++; $display("FAIL pause_spacing got=%0d exp=%0d", (nt < 2) ? -1 : t2 - t1, 10 * SCALE + 5);
    end
  endtask

  task automatic test_sync_reset();
    int ph, nt, s1, s2, t2, t3;
    logic sy;
    cycle(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, pack4(9, 0, 0, 0), 1'b1, '0, 1'b0, 1'b0);
    ph = 0; nt = 0; s1 = 0; s2 = 0; t2 = 0; t3 = 0;
    for (int i = 0; i < 200 * SCALE && nt < 3; i++) begin
      sy = 1'b0;
      if (ph == 1 && m_cnt[0] == 8) begin sy = 1'b1; ph = 2; s1 = edge_n + 1; end
      else if (ph == 3 && m_cnt[0] == 9 && model_strobe()) begin sy = 1'b1; ph = 4; s2 = edge_n + 1; end
      cycle(1'b0, junk(), 1'b0, 4'b0001, 1'b0, sy);
      n_checks++;
      if (bus.t0_n !== m_t0) begin
        n_fail++; $display("FAIL sync_t0 edge=%0d got=%b exp=%b", edge_n, bus.t0_n, m_t0);
      end
      if (sy) begin
        n_checks++;
        if (bus.t0_n[0] !== 1'b1) begin n_fail++; $display("FAIL sync_no_tick edge=%0d got=%b exp=1", edge_n, bus.t0_n[0]); end
      end
      if (bus.t0_n[0] === 1'b0) begin
        nt++;
        if (nt == 1) ph = 1;
        if (nt == 2) begin t2 = edge_n; ph = 3; end
        if (nt == 3) t3 = edge_n;
      end
    end
    n_checks += 2;
    if (nt < 2 || t2 - s1 != 10 * SCALE) begin
      n_fail++; $display("FAIL sync_restart got=%0d exp=%0d", (nt < 2) ? -1 : t2 - s1, 10 * SCALE);
    end
    if (nt < 3 || t3 - s2 != 10 * SCALE) begin
      n_fail++; $display("FAIL sync_at_wrap got=%0d exp=%0d", (nt < 3) ? -1 : t3 - s2, 10 * SCALE);
    end
    // Reset in the middle of a period: no ticks until limits are reloaded
    for (int i = 0; i < 5; i++) cycle(1'b0, junk(), 1'b0, '1, 1'b0, 1'b0);
    cycle(1'b1, junk(), 1'b0, '1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, junk(), 1'b0, '1, 1'b0, 1'b0);
      n_checks++;
      if (bus.t0_n !== {CH{1'b1}}) begin
        n_fail++; $display("FAIL reset_midrun edge=%0d got=%b exp=%b", edge_n, bus.t0_n, {CH{1'b1}});
      end
    end
    cycle(1'b0, pack4(1, 1, 1, 1), 1'b1, '1, 1'b0, 1'b0);
    for (int i = 0; i < 10 * SCALE; i++) begin
      cycle(1'b0, junk(), 1'b0, '1, 1'b0, 1'b0);
      n_checks++;
      if (bus.t0_n !== m_t0) begin
        n_fail++; $display("FAIL reset_reload edge=%0d got=%b exp=%b", edge_n, bus.t0_n, m_t0);
      end
    end
  endtask

  task automatic test_max_limit();
    cycle(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, pack4(LMAX, LMAX, LMAX, LMAX), 1'b1, '0, 1'b0, 1'b0);
    clear_ticks();
    for (int i = 0; i < 2 * (LMAX + 1) * SCALE + 8; i++) begin
      cycle(1'b0, junk(), 1'b0, '1, 1'b0, 1'b0);
      n_checks++;
      if (bus.t0_n !== m_t0) begin
        n_fail++; $display("FAIL max_t0 edge=%0d got=%b exp=%b", edge_n, bus.t0_n, m_t0);
      end
    end
    for (int k = 0; k < CH; k++) begin
      n_checks++;
      if (tq[k].size() < 2 || tq[k][1] - tq[k][0] != (LMAX + 1) * SCALE) begin
        n_fail++;
        $display("FAIL max_period ch=%0d got=%0d exp=%0d", k,
                 (tq[k].size() < 2) ? -1 : tq[k][1] - tq[k][0], (LMAX + 1) * SCALE);
      end
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] en;
    logic [BW-1:0] lb;
    logic r, ld, ps, sy;
    int v;
    en = '1;
    cycle(1'b1, '0, 1'b0, en, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      ld = ($urandom_range(0, 9) == 0);
      ps = ($urandom_range(0, 6) == 0);
      sy = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 29) == 0) en = CH'($urandom);
      lb = '0;
      for (int k = 0; k < CH; k++) begin
        v = ($urandom_range(0, 15) == 0) ? $urandom_range(0, LMAX) : $urandom_range(0, 6);
        lb[k*DW +: DW] = DW'(v);
      end
      cycle(r, lb, ld, en, ps, sy);
      n_checks++;
      if (bus.t0_n !== m_t0) begin
        n_fail++; $display("FAIL random_t0 edge=%0d got=%b exp=%b", edge_n, bus.t0_n, m_t0);
      end
    end
  endtask

  initial begin
    m_pre = 0;
    m_t0  = '1;
    test_reset();
    test_basic_period();
    test_independent();
    test_reload();
    test_pause();
    test_sync_reset();
    test_max_limit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
